// File: rtl/dnoc_c_chan_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : dnoc_c_chan_dispatch
// Purpose  : Command-channel dispatcher on the dNoC input side of a core
//            interface. Single-flit C-channel packets are classified as read
//            commands (queued in a show-ahead FIFO for the DMA read engine),
//            responses (registered pulses plus saturating counters) or sync
//            tokens (collected into a per-node mask that fires sync_done).
// Ports    : clk, rst_n               - clock, async active-low reset
//            in_flit/in_last/in_valid/in_ready - NoC input handshake
//            rd_cmd_valid/rd_cmd_ready/rd_cmd_flit - read-command FIFO head
//            dma_rd_resp/core_wr_resp - one-cycle response pulses
//            resp_cnt_dma/resp_cnt_core, cnt_clr - saturating counters
//            sync_expect/sync_pending/sync_done - sync collection
//            proto_err                - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module dnoc_c_chan_dispatch #(
  parameter int FLIT_W    = 256,
  parameter int NODE_W    = 4,
  parameter int NODES     = 2**NODE_W,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [FLIT_W-1:0] rd_cmd_flit,
  output logic              dma_rd_resp,
  output logic              core_wr_resp,
  output logic [CNT_W-1:0]  resp_cnt_dma,
  output logic [CNT_W-1:0]  resp_cnt_core,
  input  logic              cnt_clr,
  input  logic [NODES-1:0]  sync_expect,
  output logic [NODES-1:0]  sync_pending,
  output logic              sync_done,
  output logic              proto_err
);

  localparam int                 c_PTR_W    = $clog2(CMD_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W+1)'(CMD_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_INC  = CNT_W'(1);
  localparam logic [NODES-1:0]   c_ONE_NODE = NODES'(1);

  // --------------------------------------------------------------------------
  // Flit decode: the response bit dominates the sync bit.
  // --------------------------------------------------------------------------
  logic w_is_resp, w_is_sync, w_is_cmd, w_sel;
  logic w_full, w_empty, w_accept, w_push, w_pop;

  assign w_is_resp = in_flit[4];
  assign w_is_sync = !in_flit[4] && in_flit[6];
  assign w_is_cmd  = !in_flit[4] && !in_flit[6];
  assign w_sel     = in_flit[5];

  // Only read commands can be back-pressured; there is no bypass from a
  // same-cycle pop, so a full FIFO refuses commands regardless of rd_cmd_ready.
  assign in_ready  = (in_valid && !w_is_cmd) || !w_full;
  assign w_accept  = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Read-command FIFO (show-ahead, power-of-two depth, wrapping pointers)
  // --------------------------------------------------------------------------
  logic [FLIT_W-1:0]  fifo_mem_q [CMD_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_PTR_W:0]   count_q, count_d;

  assign w_full       = (count_q == c_FULL_CNT);
  assign w_empty      = (count_q == '0);
  assign rd_cmd_valid = !w_empty;
  assign rd_cmd_flit  = fifo_mem_q[rd_ptr_q];
  assign w_push       = w_accept && w_is_cmd;
  assign w_pop        = rd_cmd_valid && rd_cmd_ready;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + c_CNT_ONE;
    else if (!w_push && w_pop) count_d = count_q - c_CNT_ONE;
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Responses: registered pulses and saturating counters
  // --------------------------------------------------------------------------
  logic             w_dma_inc, w_core_inc;
  logic             dma_pulse_q, core_pulse_q;
  logic [CNT_W-1:0] cnt_dma_q, cnt_core_q;

  assign w_dma_inc  = w_accept && w_is_resp && w_sel;
  assign w_core_inc = w_accept && w_is_resp && !w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_pulse_q  <= 1'b0;
      core_pulse_q <= 1'b0;
      cnt_dma_q    <= '0;
      cnt_core_q   <= '0;
    end else begin
      dma_pulse_q  <= w_dma_inc;
      core_pulse_q <= w_core_inc;
      // Clear takes precedence over a same-cycle increment.
      if (cnt_clr)                               cnt_dma_q <= '0;
      else if (w_dma_inc && (cnt_dma_q != '1))   cnt_dma_q <= cnt_dma_q + c_CNT_INC;
      if (cnt_clr)                               cnt_core_q <= '0;
      else if (w_core_inc && (cnt_core_q != '1)) cnt_core_q <= cnt_core_q + c_CNT_INC;
    end
  end

  assign dma_rd_resp   = dma_pulse_q;
  assign core_wr_resp  = core_pulse_q;
  assign resp_cnt_dma  = cnt_dma_q;
  assign resp_cnt_core = cnt_core_q;

  // --------------------------------------------------------------------------
  // Sync collection. Completion is checked every cycle, not only on a sync
  // accept, so shrinking sync_expect can complete an already-pending set.
  // --------------------------------------------------------------------------
  logic [NODES-1:0] w_new, w_merged, pending_q;
  logic             w_hit, w_dup, done_q;

  assign w_new    = (w_accept && w_is_sync) ? (c_ONE_NODE << in_flit[7 +: NODE_W]) : '0;
  assign w_merged = pending_q | w_new;
  assign w_hit    = ((w_merged & sync_expect) == sync_expect) && (sync_expect != '0);
  assign w_dup    = |(pending_q & w_new);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= w_hit;
      pending_q <= w_hit ? (w_merged & ~sync_expect) : w_merged;
    end
  end

  assign sync_pending = pending_q;
  assign sync_done    = done_q;

  // --------------------------------------------------------------------------
  // Sticky protocol error. Popping an empty FIFO cannot happen because
  // rd_cmd_valid gates the pop; the term is kept as a structural guard.
  // --------------------------------------------------------------------------
  logic w_err, err_q;

  assign w_err = (w_accept && !in_last) || w_dup || (w_pop && w_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (w_err) err_q <= 1'b1;
  end

  assign proto_err = err_q;

endmodule
`default_nettype wire

// File: doc/dnoc_c_chan_dispatch.md
# dnoc_c_chan_dispatch

Parametrised command-channel dispatcher on the dNoC input side of a core interface. It accepts single-flit C-channel packets and classifies each as a read command, a write/read response, or a sync token. Read commands are buffered in a show-ahead FIFO for the DMA read engine. Responses are reported as registered pulses with saturating counters. Sync tokens are collected into a per-node bitmask that fires `sync_done` once every expected node has arrived.

## Interface
- `FLIT_W`, 256: flit width; must be ≥ 11.
- `NODE_W`, 4: node-id width; the id is carried in `in_flit[7+NODE_W-1:7]`.
- `NODES`, 2**NODE_W: sync mask width.
- `CMD_DEPTH`, 4: read-command FIFO depth; power of two, ≥ 2.
- `CNT_W`, 8: response counter width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_flit` in FLIT_W: NoC flit.
- `in_last` in 1: end-of-packet marker; must be 1 on every flit.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `rd_cmd_valid` out 1 / `rd_cmd_ready` in 1: read-command output handshake.
- `rd_cmd_flit` out FLIT_W: FIFO head, i.e. the raw command flit; the DMA decodes the config fields.
- `dma_rd_resp` out 1: pulse; response flit with sel=1.
- `core_wr_resp` out 1: pulse; response flit with sel=0.
- `resp_cnt_dma`, `resp_cnt_core` out CNT_W: saturating response counts.
- `cnt_clr` in 1: synchronous clear of both counters.
- `sync_expect` in NODES: set of nodes required for a sync.
- `sync_pending` out NODES: nodes that have arrived and are not yet consumed.
- `sync_done` out 1: pulse; sync complete.
- `proto_err` out 1: sticky protocol error flag, cleared only by reset.

## Operation
- Flit type decode, applied when a flit is accepted:
  - `in_flit[4]`=1: response.
  - else `in_flit[6]`=1: sync.
  - else: read command.
  - `in_flit[4]` has priority over `in_flit[6]`.
  - `in_flit[5]` is sel.
- `in_ready` is combinational:
  - read command: `!fifo_full`;
  - response or sync: 1;
  - `in_valid`=0: `!fifo_full`.
- An accept is `in_valid && in_ready`. No internal state machine; every flit is consumed in one cycle.
- Read command: pushed into the FIFO. `rd_cmd_valid` = `!fifo_empty`. A pop is `rd_cmd_valid && rd_cmd_ready`.
  - Push and pop in the same cycle when the FIFO is not full: both take effect, count unchanged.
  - When full, `in_ready` stays 0 even if a pop occurs that cycle; there is no bypass.
- Response: a one-cycle pulse on `dma_rd_resp` or `core_wr_resp`; the matching counter increments.
  - Counters saturate at 2**CNT_W-1.
  - `cnt_clr` wins over a same-cycle increment; the result is 0.
- Sync: `new = onehot(in_flit[7+:NODE_W])`.
  - `hit = ((sync_pending | new) & sync_expect) == sync_expect && sync_expect != 0`.
  - If `hit`: next cycle `sync_pending <= (sync_pending | new) & ~sync_expect` and `sync_done` pulses.
  - Otherwise: `sync_pending <= sync_pending | new`.
  - `hit` is also evaluated on cycles with no sync accept (`new`=0), so lowering `sync_expect` can complete a pending set.
- `proto_err` sets on any of:
  - an accepted flit with `in_last`=0 (the flit is still processed);
  - a sync from a node whose pending bit is already set (mask unchanged);
  - a FIFO pop when empty, which is impossible by construction; the assertion only.

## Timing
- Reset (async, `rst_n`=0) state:
  - FIFO empty; `rd_cmd_valid`=0.
  - `dma_rd_resp`=`core_wr_resp`=0; counters 0.
  - `sync_pending`=0; `sync_done`=0; `proto_err`=0.
  - `in_ready`=1.
- Reset mid-operation discards FIFO contents and pending sync bits; no pulse is emitted.
- Latencies:
  - Accept at cycle t to `rd_cmd_valid` at t+1 (empty FIFO).
  - Response accept at t: pulse and counter update visible at t+1.
  - Sync accept completing the set at t: `sync_done`=1 during t+1, with `sync_pending` already cleared.
- Pulses are exactly one cycle. Back-to-back responses give back-to-back pulses.
- `rd_cmd_flit` is stable while `rd_cmd_valid`=1 and not popped.

## Test plan
- Reset, then 5 read-command flits with `rd_cmd_ready`=0 and CMD_DEPTH=4 -> 4 accepted; `in_ready`=0 on the 5th. Raise ready -> flits popped in order, 5th accepted a cycle after the first pop, no loss.
- Response flits with bit5=1, 0, 1 on consecutive cycles -> `dma_rd_resp`, `core_wr_resp`, `dma_rd_resp` pulses at t+1..t+3; final counts dma=2, core=1.
- 300 core responses with CNT_W=8 -> `resp_cnt_core`=255. `cnt_clr` asserted together with a response -> count 0.
- `sync_expect`=0x000B; syncs from nodes 0, 3, 1 -> `sync_pending` goes 0x1, 0x9, then 0; `sync_done` pulses the cycle after node 1's accept. A second sync from node 3 before completion -> `proto_err`=1.
- Flit with bits 4 and 6 both set, bit5=0 -> treated as a response, `core_wr_resp` pulse, `sync_pending` unchanged.
- Assert reset with 3 commands queued and `sync_pending`=0x2 -> `rd_cmd_valid`=0 and `sync_pending`=0 immediately; no pulses after reset release.
